i2s_tdm_transmitter: RTL and testbench

Parametrised successor to the team's 2-channel I2S serialiser. It generates its own SCLK/LRCLK from the single system clock, buffers whole frames in a small sample FIFO behind a valid/ready handshake, and supports N-channel TDM, slot width wider than sample width, and standard-I2S or left-justified framing. It sits between the audio mixer and the codec pins.

---
 rtl/i2s_pkg.sv | 21 ++
 rtl/i2s_sample_fifo.sv | 64 ++++++
 rtl/i2s_tdm_transmitter.sv | 149 ++++++++++++++
 tb/tb_i2s_tdm_transmitter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S/TDM transmitter.
package i2s_pkg;

   // Framing: standard I2S delays data by one SCLK, left-justified does not
   typedef enum logic {
      I2S_STD = 1'b0,
      I2S_LJ  = 1'b1
   } i2s_mode_t;

   // Serialiser control states
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } i2s_state_t;

   // Number of SCLK bits in one full frame
   function automatic int slot_bits(input int channels, input int slot);
      return channels * slot;
   endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Single-clock frame FIFO. Read data is the head entry, valid whenever
// empty_o is low; a pop advances to the next entry on the clock edge.
module i2s_sample_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [DATA_W-1:0]          data_i,
   input  logic                       pop_i,
   output logic [DATA_W-1:0]          data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [LW-1:0]     count_q;
   logic              do_push;
   logic              do_pop;

   // A full FIFO refuses pushes even if a pop frees a slot this cycle
   assign full_o  = (count_q == LW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];
   assign level_o = count_q;

   // Storage array; no reset so it maps onto plain RAM
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + LW'(1);
            2'b01:   count_q <= count_q - LW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/i2s_tdm_transmitter.sv
// I2S / left-justified / TDM serialiser with on-chip SCLK/LRCLK generation
// and a small frame FIFO in front of the shift register.
module i2s_tdm_transmitter
   import i2s_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int SLOT       = 16,
   parameter int CHANNELS   = 2,
   parameter int CLK_DIV    = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int MODE       = 0
) (
   input  logic                            Clock,
   input  logic                            nReset,
   input  logic                            onOff,
   input  logic                            InValid,
   output logic                            InReady,
   input  logic [CHANNELS*WIDTH-1:0]       InData,
   output logic                            SCLK,
   output logic                            LRCLK,
   output logic                            SD,
   output logic                            Underrun,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] Level
);

   localparam int        FRAME_W = slot_bits(CHANNELS, SLOT);
   localparam int        HALF    = FRAME_W / 2;
   localparam int        CNT_W   = $clog2(FRAME_W);
   localparam int        DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam i2s_mode_t MODE_T  = (MODE == 1) ? I2S_LJ : I2S_STD;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [CHANNELS*WIDTH-1:0] fifo_data;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [FRAME_W-1:0]        frame_exp;

   i2s_state_t         state_q;
   logic [DIV_W-1:0]   div_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic [FRAME_W-1:0] shreg_q;
   logic [FRAME_W-1:0] shreg_d;
   logic               sclk_q;
   logic               lrclk_q;
   logic               lrclk_d;
   logic               sd_q;
   logic               sd_d;
   logic               underrun_q;
   logic               fall_tick;
   logic               frame_start;
   logic               pop;

   i2s_sample_fifo #(
      .DATA_W (CHANNELS * WIDTH),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (Clock),
      .rst_ni  (nReset),
      .push_i  (InValid),
      .data_i  (InData),
      .pop_i   (pop),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (Level)
   );

   // Left-align each channel's sample in its slot and zero the padding
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_slot
      assign frame_exp[FRAME_W-1-gi*SLOT -: SLOT] =
         SLOT'(fifo_data[CHANNELS*WIDTH-1-gi*WIDTH -: WIDTH]) << (SLOT - WIDTH);
   end

   // Next bit position, shift-register contents and pin values at a fall_tick
   always_comb begin
      fall_tick = 1'b0;
      cnt_d     = '0;
      if (state_q == ST_IDLE) begin
         // The very first edge of a run acts as a falling SCLK edge
         fall_tick = onOff;
      end else begin
         fall_tick = onOff & sclk_q & (div_q == DIV_LAST);
         if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      frame_start = fall_tick & (cnt_d == '0);
      pop         = frame_start & ~fifo_empty;
      if (cnt_d == '0) begin
         shreg_d = fifo_empty ? '0 : frame_exp;
      end else begin
         shreg_d = shreg_q << 1;
      end
      // Standard I2S emits the bit presented one SCLK earlier
      sd_d    = (MODE_T == I2S_LJ) ? shreg_d[FRAME_W-1] : shreg_q[FRAME_W-1];
      lrclk_d = (cnt_d >= CNT_W'(HALF));
   end

   // Control FSM, clock divider, bit counter and registered pin drivers
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q    <= ST_IDLE;
         div_q      <= '0;
         cnt_q      <= '0;
         shreg_q    <= '0;
         sclk_q     <= 1'b0;
         lrclk_q    <= 1'b0;
         sd_q       <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         underrun_q <= 1'b0;
         if (state_q == ST_RUN && !onOff) begin
            // Abandon the frame in flight; queued frames stay in the FIFO
            state_q <= ST_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
            sd_q    <= 1'b0;
         end else if (fall_tick) begin
            state_q    <= ST_RUN;
            div_q      <= '0;
            sclk_q     <= 1'b0;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            lrclk_q    <= lrclk_d;
            sd_q       <= sd_d;
            underrun_q <= frame_start & fifo_empty;
         end else if (state_q == ST_RUN) begin
            if (div_q == DIV_LAST) begin
               sclk_q <= ~sclk_q;
               div_q  <= '0;
            end else begin
               div_q <= div_q + 1'b1;
            end
         end
      end
   end

   assign InReady  = ~fifo_full;
   assign SCLK     = sclk_q;
   assign LRCLK    = lrclk_q;
   assign SD       = sd_q;
   assign Underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tdm_transmitter.sv
// Directed bench for the I2S/TDM transmitter: default I2S instance, a
// 24-bit-slot left-justified instance and a 4-channel TDM instance.
module tb_i2s_tdm_transmitter;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        on_off   = 1'b0;
   logic        in_valid = 1'b0;
   logic [63:0] in_data  = '0;
   logic [1:0]  sel      = 2'd0;

   int tests  = 0;
   int failed = 0;

   logic       on_a, val_a, rdy_a, sclk_a, lr_a, sd_a, und_a;
   logic [2:0] lvl_a;
   logic       on_b, val_b, rdy_b, sclk_b, lr_b, sd_b, und_b;
   logic [2:0] lvl_b;
   logic       on_c, val_c, rdy_c, sclk_c, lr_c, sd_c, und_c;
   logic [2:0] lvl_c;

   logic       sclk_m, lr_m, sd_m, und_m, rdy_m;
   logic [2:0] lvl_m;

   always #5 clk = ~clk;

   assign on_a  = on_off & (sel == 2'd0);
   assign val_a = in_valid & (sel == 2'd0);
   assign on_b  = on_off & (sel == 2'd1);
   assign val_b = in_valid & (sel == 2'd1);
   assign on_c  = on_off & (sel == 2'd2);
   assign val_c = in_valid & (sel == 2'd2);

   assign sclk_m = (sel == 2'd0) ? sclk_a : (sel == 2'd1) ? sclk_b : sclk_c;
   assign lr_m   = (sel == 2'd0) ? lr_a   : (sel == 2'd1) ? lr_b   : lr_c;
   assign sd_m   = (sel == 2'd0) ? sd_a   : (sel == 2'd1) ? sd_b   : sd_c;
   assign und_m  = (sel == 2'd0) ? und_a  : (sel == 2'd1) ? und_b  : und_c;
   assign rdy_m  = (sel == 2'd0) ? rdy_a  : (sel == 2'd1) ? rdy_b  : rdy_c;
   assign lvl_m  = (sel == 2'd0) ? lvl_a  : (sel == 2'd1) ? lvl_b  : lvl_c;

   i2s_tdm_transmitter dut_a (
      .Clock(clk), .nReset(rst_n), .onOff(on_a), .InValid(val_a), .InReady(rdy_a),
      .InData(in_data[31:0]), .SCLK(sclk_a), .LRCLK(lr_a), .SD(sd_a),
      .Underrun(und_a), .Level(lvl_a)
   );

   i2s_tdm_transmitter #(.SLOT(24), .MODE(1)) dut_b (
      .Clock(clk), .nReset(rst_n), .onOff(on_b), .InValid(val_b), .InReady(rdy_b),
      .InData(in_data[31:0]), .SCLK(sclk_b), .LRCLK(lr_b), .SD(sd_b),
      .Underrun(und_b), .Level(lvl_b)
   );

   i2s_tdm_transmitter #(.CHANNELS(4), .MODE(1)) dut_c (
      .Clock(clk), .nReset(rst_n), .onOff(on_c), .InValid(val_c), .InReady(rdy_c),
      .InData(in_data), .SCLK(sclk_c), .LRCLK(lr_c), .SD(sd_c),
      .Underrun(und_c), .Level(lvl_c)
   );

   task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [63:0] d);
      @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Record SD/LRCLK at each SCLK rise (first rise ends up in the MSB),
   // Underrun-high Clocks, Level every 32 rises and the rise-to-rise span.
   task automatic collect(input int n, output logic [191:0] sdv, output logic [191:0] lrv,
                          output int nund, output int span, output logic [14:0] lvls,
                          output logic tmo);
      int   cyc;
      int   got;
      int   first_cyc;
      logic prev;
      sdv = '0; lrv = '0; nund = 0; span = 0; lvls = '0; tmo = 1'b0;
      cyc = 0; got = 0; first_cyc = 0;
      prev = sclk_m;
      while (got < n) begin
         @(negedge clk);
         cyc++;
         if (und_m) nund++;
         if (sclk_m && !prev) begin
            sdv = {sdv[190:0], sd_m};
            lrv = {lrv[190:0], lr_m};
            if (got % 32 == 0) lvls = {lvls[11:0], lvl_m};
            if (got == 0) first_cyc = cyc;
            span = cyc - first_cyc;
            got++;
         end
         prev = sclk_m;
         if (cyc > n * 8 + 40) begin
            tmo = 1'b1;
            break;
         end
      end
   endtask

   logic [191:0] sdv, lrv;
   int           nund, span;
   logic [14:0]  lvls;
   logic         tmo;

   initial begin
      // Power-on reset
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_sclk", sclk_m, 0);
      check("rst_lrclk", lr_m, 0);
      check("rst_sd", sd_m, 0);
      check("rst_underrun", und_m, 0);
      check("rst_level", lvl_m, 0);
      check("rst_inready", rdy_m, 1);

      // Single frame, standard I2S: SD is 0 at count 0, then the frame bits
      push(64'hA5A5_0F0F);
      check("single_level_pre", lvl_m, 1);
      @(negedge clk);
      on_off = 1'b1;
      collect(64, sdv, lrv, nund, span, lvls, tmo);
      check("single_timeout", tmo, 0);
      check("single_sd", sdv, {1'b0, 32'hA5A5_0F0F, 31'd0});
      check("single_lrclk", lrv, {2{32'h0000_FFFF}});
      check("single_sclk_span", span, 4 * 63);
      check("single_underruns", nund, 1);
      check("single_level_post", lvl_m, 0);

      // Back to idle: SCLK parked low
      @(negedge clk);
      on_off = 1'b0;
      repeat (6) @(negedge clk);
      check("idle_sclk", sclk_m, 0);

      // Underrun from an empty FIFO: silent data, frame clock keeps running
      on_off = 1'b1;
      collect(64, sdv, lrv, nund, span, lvls, tmo);
      check("under_timeout", tmo, 0);
      check("under_sd", sdv, 0);
      check("under_lrclk", lrv, {2{32'h0000_FFFF}});
      check("under_pulses", nund, 2);
      check("under_lr_high_pre_reset", lr_m, 1);

      // Asynchronous reset mid-run, between Clock edges
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_sclk", sclk_m, 0);
      check("arst_lrclk", lr_m, 0);
      check("arst_sd", sd_m, 0);
      check("arst_underrun", und_m, 0);
      @(negedge clk);
      on_off = 1'b0;
      rst_n  = 1'b1;
      repeat (8) @(negedge clk);
      check("arst_inready", rdy_m, 1);
      check("arst_level", lvl_m, 0);
      check("arst_sclk_idle", sclk_m, 0);

      // Backpressure: four frames fill the FIFO, the fifth is dropped
      push(64'h1111_0001);
      push(64'h2222_0002);
      push(64'h3333_0003);
      push(64'h4444_0004);
      check("full_inready", rdy_m, 0);
      check("full_level", lvl_m, 4);
      push(64'h5555_0005);
      check("full_level_after_5th", lvl_m, 4);
      @(negedge clk);
      on_off = 1'b1;
      collect(160, sdv, lrv, nund, span, lvls, tmo);
      check("full_timeout", tmo, 0);
      check("full_sd", sdv, {1'b0, 128'h1111_0001_2222_0002_3333_0003_4444_0004, 31'd0});
      check("full_lrclk", lrv, {5{32'h0000_FFFF}});
      check("full_levels", lvls, {3'd3, 3'd2, 3'd1, 3'd0, 3'd0});
      check("full_underruns", nund, 1);
      @(negedge clk);
      on_off = 1'b0;

      // Wide slot, left-justified: 24-bit slots, MSB on the LRCLK fall
      sel = 2'd1;
      push(64'hFFFF_8001);
      check("wide_level_pre", lvl_m, 1);
      @(negedge clk);
      on_off = 1'b1;
      collect(48, sdv, lrv, nund, span, lvls, tmo);
      check("wide_timeout", tmo, 0);
      check("wide_sd", sdv, 48'hFFFF00_800100);
      check("wide_lrclk", lrv, 48'h000000_FFFFFF);
      check("wide_sclk_span", span, 4 * 47);
      @(negedge clk);
      on_off = 1'b0;

      // Four-channel TDM, left-justified: one '1' per slot, walking right
      sel = 2'd2;
      push(64'h8000_4000_2000_1000);
      @(negedge clk);
      on_off = 1'b1;
      collect(64, sdv, lrv, nund, span, lvls, tmo);
      check("tdm_timeout", tmo, 0);
      check("tdm_sd", sdv, 64'h8000_4000_2000_1000);
      check("tdm_lrclk", lrv, 64'h0000_0000_FFFF_FFFF);
      check("tdm_underruns", nund, 0);
      @(negedge clk);
      on_off = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
